// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter that sequences
// ownership of the 2-bit 4x1 mux output channel.
package mux_arb_pkg;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

   // Lowest set bit wins; callers only pass one-hot or zero vectors.
   function automatic logic [SEL_W-1:0] encode(input logic [N_REQ-1:0] vec);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (vec[i]) idx = SEL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first requester in circular order
// ptr+1, ptr+2, ptr+3, ptr.
module rr_picker
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] idx,
   output logic             any_req
);

   logic [SEL_W-1:0] cand;

   // Walk the order backwards so the nearest candidate after ptr is written last.
   always_comb begin
      idx     = ptr;
      cand    = ptr;
      any_req = |req;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = ptr + SEL_W'(k);
         if (req[cand]) idx = cand;
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with bounded hold time that drives the select of the
// shared 4x1 mux; grant, select and busy are all registered.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int HOLD_W   = 3
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic [N_REQ-1:0] Req,
   output logic [N_REQ-1:0] Grant,
   output logic [SEL_W-1:0] Sel,
   output logic             Busy
);

   localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

   arb_state_t        state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [SEL_W-1:0]  ptr_q, ptr_d;
   logic [N_REQ-1:0]  grant_d;
   logic [SEL_W-1:0]  sel_d;
   logic              busy_d;

   logic [SEL_W-1:0]  pick_idx;
   logic              pick_any;
   logic              others_req;

   // While granted, ptr_q is the current owner, so a single picker serves both
   // the idle search and the handover/rotation search.
   rr_picker u_picker (
      .req     (Req),
      .ptr     (ptr_q),
      .idx     (pick_idx),
      .any_req (pick_any)
   );

   assign others_req = |(Req & ~onehot(ptr_q));

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      ptr_d   = ptr_q;
      grant_d = Grant;
      sel_d   = Sel;
      busy_d  = Busy;
      unique case (state_q)
         IDLE: begin
            grant_d = '0;
            busy_d  = 1'b0;
            if (pick_any) begin
               state_d = GRANT;
               grant_d = onehot(pick_idx);
               sel_d   = pick_idx;
               busy_d  = 1'b1;
               hold_d  = HOLD_W'(1);
               ptr_d   = pick_idx;
            end
         end
         GRANT: begin
            if (!Req[ptr_q]) begin
               if (pick_any) begin
                  grant_d = onehot(pick_idx);
                  sel_d   = pick_idx;
                  hold_d  = HOLD_W'(1);
                  ptr_d   = pick_idx;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  busy_d  = 1'b0;
               end
            end else if (hold_q == MAX_HOLD_C && others_req) begin
               grant_d = onehot(pick_idx);
               sel_d   = pick_idx;
               hold_d  = HOLD_W'(1);
               ptr_d   = pick_idx;
            end else if (hold_q != MAX_HOLD_C) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         ptr_q   <= SEL_W'(N_REQ - 1);
         Grant   <= '0;
         Sel     <= '0;
         Busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         ptr_q   <= ptr_d;
         Grant   <= grant_d;
         Sel     <= sel_d;
         Busy    <= busy_d;
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed-vector bench for mux_rr_arbiter with MAX_HOLD=4.
module tb_mux_rr_arbiter;
   import mux_arb_pkg::*;

   logic             Clk;
   logic             Rst_n;
   logic [N_REQ-1:0] Req;
   logic [N_REQ-1:0] Grant;
   logic [SEL_W-1:0] Sel;
   logic             Busy;

   int n_vec = 0;
   int n_err = 0;

   mux_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(3)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .Req   (Req),
      .Grant (Grant),
      .Sel   (Sel),
      .Busy  (Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                          input logic b);
      chk({tag, ".grant"}, 32'(Grant), 32'(g));
      chk({tag, ".sel"},   32'(Sel),   32'(s));
      chk({tag, ".busy"},  32'(Busy),  32'(b));
   endtask

   logic [1:0] exp_own;

   initial begin
      Rst_n = 1'b0;
      Req   = 4'b1111;

      // Reset with all requesting, then first grant goes to source 0
      for (int i = 0; i < 2; i++) begin
         tick();
         chk_out("rst", 4'b0000, 2'b00, 1'b0);
      end
      Rst_n = 1'b1;
      tick();
      chk_out("first", 4'b0001, 2'b00, 1'b1);

      // Sole requester 2: handover from 0, then held indefinitely
      Req = 4'b0100;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_out("sole", 4'b0100, 2'b10, 1'b1);
      end
      Req = 4'b0000;
      tick();
      chk_out("idle", 4'b0000, 2'b10, 1'b0);

      // Pointer retained at 2 across idle: order is 3,0,1,2
      Req = 4'b0101;
      tick();
      chk_out("ptr", 4'b0001, 2'b00, 1'b1);

      // All requesting: 4 cycles each owner, first of source 0 already seen
      Req = 4'b1111;
      for (int k = 1; k <= 16; k++) begin
         tick();
         exp_own = 2'((k / 4) % 4);
         chk("hold.grant", 32'(Grant), 32'(onehot(exp_own)));
         chk("hold.sel",   32'(Sel),   32'(exp_own));
      end

      // Release handover without an idle bubble
      Req = 4'b0011;
      tick();
      chk_out("rel2nd", 4'b0001, 2'b00, 1'b1);
      Req = 4'b0010;
      tick();
      chk_out("handover", 4'b0010, 2'b01, 1'b1);

      // Reset mid-grant, then last_ptr is back at 3
      Req = 4'b1000;
      tick();
      chk_out("own3", 4'b1000, 2'b11, 1'b1);
      Rst_n = 1'b0;
      tick();
      chk_out("midrst", 4'b0000, 2'b00, 1'b0);
      Rst_n = 1'b1;
      Req   = 4'b1001;
      tick();
      chk_out("postrst", 4'b0001, 2'b00, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
